status_pc: RTL and testbench

STATUS_PC -- requirements
Module: status_pc

---
 rtl/status_pc.sv | 39 +++
 tb/tb_status_pc.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/status_pc.sv
// Program-counter status register: holds the fetch PC with stall support and
// exposes the wrapped PC+4 / PC+8 views plus a word-alignment indicator.
module status_pc #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] pc_prim,
  output logic [WIDTH-1:0] pc,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] pc_plus8,
  output logic             misaligned
);

  // Unsigned add that silently drops the carry out of the top bit.
  function automatic logic [WIDTH-1:0] add_wrap(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    add_wrap = a + b;
  endfunction

  // The only state in the block: pc itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_VALUE;
    end else if (en) begin
      pc <= pc_prim;
    end
  end

  // Derived views depend on the registered pc only, never on pc_prim.
  always_comb begin
    pc_plus4   = add_wrap(pc, WIDTH'(4));
    pc_plus8   = add_wrap(pc, WIDTH'(8));
    misaligned = |pc[1:0];
  end

endmodule

// File: tb/tb_status_pc.sv
// Directed bench for status_pc: load/stall, async reset, wrap-around and alignment.
module tb_status_pc;

  logic        clk;
  logic [31:0] pc_prim;
  logic [31:0] pc;
  logic        rst_n;
  logic        en;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus8;
  logic        misaligned;

  int tests_run = 0;
  int tests_failed = 0;

  status_pc #(.WIDTH(32), .RESET_VALUE(32'h0)) dut (
    .clk        (clk),
    .pc_prim    (pc_prim),
    .pc         (pc),
    .rst_n      (rst_n),
    .en         (en),
    .pc_plus4   (pc_plus4),
    .pc_plus8   (pc_plus8),
    .misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive pc_prim at the falling edge, then settle just past the next rising edge.
  task automatic load(input logic [31:0] v);
    @(negedge clk);
    pc_prim = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    en      = 1'b1;
    pc_prim = 32'h0;
    #1;
    check("reset_pc",    pc,               32'h0);
    check("reset_plus4", pc_plus4,         32'h4);
    check("reset_plus8", pc_plus8,         32'h8);
    check("reset_mis",   {31'b0, misaligned}, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // Ramp 0..10, one value per cycle.
    for (int i = 0; i <= 10; i++) begin
      load(32'(i));
      check("ramp_pc",    pc,       32'(i));
      check("ramp_plus4", pc_plus4, 32'(i + 4));
    end

    // Stall: hold 0x100 for three edges while pc_prim shows 0x200.
    load(32'h100);
    check("stall_load", pc, 32'h100);
    @(negedge clk);
    en      = 1'b0;
    pc_prim = 32'h200;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stall_hold", pc, 32'h100);
    end
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    check("stall_release", pc, 32'h200);

    // Mid-cycle change of pc_prim must not leak through.
    load(32'h300);
    check("midcyc_load", pc, 32'h300);
    #2;
    pc_prim = 32'h777;
    #1;
    check("midcyc_hold",  pc,       32'h300);
    check("midcyc_plus4", pc_plus4, 32'h304);
    @(posedge clk);
    #1;
    check("midcyc_next", pc, 32'h777);

    // Asynchronous reset between edges, then held across edges.
    load(32'h1234);
    check("arst_pre", pc, 32'h1234);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_imm",   pc,       32'h0);
    check("arst_plus8", pc_plus8, 32'h8);
    pc_prim = 32'h55;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("arst_held", pc, 32'h0);
    end
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    check("arst_held_en0", pc, 32'h0);
    @(negedge clk);
    rst_n   = 1'b1;
    en      = 1'b1;
    pc_prim = 32'h88;
    @(posedge clk);
    #1;
    check("arst_first_load", pc, 32'h88);

    // Wrap-around of the derived values.
    load(32'hFFFF_FFFC);
    check("wrap_pc",    pc,       32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4, 32'h0000_0000);
    check("wrap_plus8", pc_plus8, 32'h0000_0004);
    check("wrap_mis",   {31'b0, misaligned}, 32'h0);
    load(32'hFFFF_FFFF);
    check("wrap2_plus4", pc_plus4, 32'h0000_0003);
    check("wrap2_plus8", pc_plus8, 32'h0000_0007);
    check("wrap2_mis",   {31'b0, misaligned}, 32'h1);

    // Misaligned pc is still loaded and flagged.
    load(32'h6);
    check("mis6_pc",  pc, 32'h6);
    check("mis6_flag", {31'b0, misaligned}, 32'h1);
    load(32'h8);
    check("mis8_pc",   pc, 32'h8);
    check("mis8_flag", {31'b0, misaligned}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
